// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexes one active-low segment bus across a
// 4-digit common-anode display. Each digit gets a slot of REFRESH_DIV cycles.
// The first GUARD cycles of each slot keep every anode off so the previous
// digit's pattern cannot ghost onto the new anode.
module seg_scan_controller #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 1000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] blank,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] slot_idx,
  output logic       slot_tick
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W:0]   GUARD_X = (CNT_W+1)'(GUARD);

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       idx_n;
  logic             fresh, fresh_n;   // set by reset: next enabled edge starts slot 0
  logic [3:0]       val, val_n;       // digit value latched at slot start
  logic             blk, blk_n;       // blank bit latched at slot start
  logic             tick_n;
  logic [3:0]       an_n;
  logic [6:0]       seg_n;
  logic             drive;

  // Active-low hex decode, bit order g..a.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Next-state: advance the refresh counter and latch the new slot's inputs.
  always_comb begin
    cnt_n   = cnt;
    idx_n   = slot_idx;
    fresh_n = fresh;
    val_n   = val;
    blk_n   = blk;
    tick_n  = 1'b0;
    if (enable) begin
      if (fresh || cnt == LAST) begin
        cnt_n   = '0;
        tick_n  = 1'b1;
        fresh_n = 1'b0;
        if (!fresh) idx_n = slot_idx + 2'd1;
        case (idx_n)
          2'd0:    val_n = digit0;
          2'd1:    val_n = digit1;
          2'd2:    val_n = digit2;
          default: val_n = digit3;
        endcase
        blk_n = blank[idx_n];
      end else begin
        cnt_n = cnt + CNT_W'(1);
      end
    end
  end

  // Outputs from next-state values so the registered an/seg line up with cnt/slot_idx.
  always_comb begin
    drive = (({1'b0, cnt_n} + (CNT_W+1)'(1)) > GUARD_X);  // cnt_n >= GUARD
    an_n  = 4'b1111;
    seg_n = 7'b1111111;
    if (enable && !blk_n && drive) begin
      an_n  = ~(4'b0001 << idx_n);
      seg_n = hex7(val_n);
    end
  end

  // State and output registers; synchronous reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      slot_idx  <= 2'd0;
      fresh     <= 1'b1;
      val       <= 4'h0;
      blk       <= 1'b1;
      slot_tick <= 1'b0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
    end else begin
      cnt       <= cnt_n;
      slot_idx  <= idx_n;
      fresh     <= fresh_n;
      val       <= val_n;
      blk       <= blk_n;
      slot_tick <= tick_n;
      an        <= an_n;
      seg       <= seg_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with a per-cycle scoreboard plus
// literal checks taken from the display behaviour. A second instance with
// GUARD=0 shares the stimulus.
module tb_seg_scan_controller;

  localparam int DIV = 8;
  localparam int GD  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] digit0 = 4'h1, digit1 = 4'h2, digit2 = 4'h3, digit3 = 4'h4;
  logic [3:0] blank = 4'b0000;
  logic [6:0] seg, seg0;
  logic [3:0] an, an0;
  logic [1:0] slot_idx, slot_idx0;
  logic       slot_tick, slot_tick0;

  seg_scan_controller #(.REFRESH_DIV(DIV), .GUARD(GD), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blank(blank), .seg(seg), .an(an), .slot_idx(slot_idx), .slot_tick(slot_tick)
  );

  seg_scan_controller #(.REFRESH_DIV(DIV), .GUARD(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blank(blank), .seg(seg0), .an(an0), .slot_idx(slot_idx0), .slot_tick(slot_tick0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [1:0] idx;
    logic       tick;
    logic [3:0] an0;
    logic [6:0] seg0;
  } exp_t;

  exp_t sbq[$];
  int   npass = 0;
  int   nchk  = 0;

  // bench-side model of the scan position
  int         m_cnt = 0, m_idx = 0;
  bit         m_fresh = 1'b1;
  logic [3:0] m_val = 4'h0;
  logic       m_blk = 1'b1;

  logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] seg_tab [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'h0: dec = 7'b1000000; 4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100; 4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001; 4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010; 4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000; 4'h9: dec = 7'b0010000;
      4'hA: dec = 7'b0001000; 4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110; 4'hD: dec = 7'b0100001;
      4'hE: dec = 7'b0000110; default: dec = 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Push the expected post-edge outputs for the inputs about to be sampled.
  task automatic predict();
    exp_t       e;
    logic [3:0] one = 4'b0001;
    logic       on;
    e.tick = 1'b0;
    if (reset) begin
      m_cnt = 0; m_idx = 0; m_fresh = 1'b1; m_val = 4'h0; m_blk = 1'b1;
    end else if (enable) begin
      if (m_fresh || m_cnt == DIV-1) begin
        if (!m_fresh) m_idx = (m_idx + 1) % 4;
        m_cnt = 0; m_fresh = 1'b0; e.tick = 1'b1;
        case (m_idx)
          0: m_val = digit0;
          1: m_val = digit1;
          2: m_val = digit2;
          default: m_val = digit3;
        endcase
        m_blk = blank[m_idx];
      end else begin
        m_cnt++;
      end
    end
    on     = !reset && enable && !m_blk;
    e.idx  = 2'(m_idx);
    e.an   = (on && m_cnt >= GD) ? ~(one << m_idx) : 4'b1111;
    e.seg  = (on && m_cnt >= GD) ? dec(m_val) : 7'b1111111;
    e.an0  = on ? ~(one << m_idx) : 4'b1111;
    e.seg0 = on ? dec(m_val) : 7'b1111111;
    sbq.push_back(e);
  endtask

  // One clock: predict, clock, then pop and compare away from the edge.
  task automatic cyc();
    exp_t e;
    predict();
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("sb_an",   16'(an),        16'(e.an));
    check("sb_seg",  16'(seg),       16'(e.seg));
    check("sb_idx",  16'(slot_idx),  16'(e.idx));
    check("sb_tick", 16'(slot_tick), 16'(e.tick));
    check("sb_an_g0",  16'(an0),  16'(e.an0));
    check("sb_seg_g0", 16'(seg0), 16'(e.seg0));
    check("an_onehot",    16'($countones(~an)  <= 1), 16'(1));
    check("an_onehot_g0", 16'($countones(~an0) <= 1), 16'(1));
  endtask

  task automatic run_until(input int i, input int c);
    int n = 0;
    while (!(m_idx == i && m_cnt == c) && n < 200) begin
      cyc();
      n++;
    end
    check("reach_pos", 16'(m_idx == i && m_cnt == c), 16'(1));
  endtask

  initial begin
    // reset and first slot
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("rst_an", 16'(an), 16'(4'b1111));
      check("rst_seg", 16'(seg), 16'(7'b1111111));
    end
    reset = 1'b0;
    cyc();
    check("first_tick", 16'(slot_tick), 16'(1));
    check("first_idx",  16'(slot_idx),  16'(0));
    check("guard_an",   16'(an),        16'(4'b1111));
    check("g0_start_an", 16'(an0),      16'(4'b1110));
    cyc();
    check("guard_an1", 16'(an), 16'(4'b1111));
    for (int k = 2; k < DIV; k++) begin
      cyc();
      check("slot0_an",  16'(an),  16'(4'b1110));
      check("slot0_seg", 16'(seg), 16'(7'b1111001));
    end

    // full rotation
    for (int k = 1; k <= 32; k++) begin
      int s, c;
      s = ((k - 1) / 8 + 1) % 4;
      c = (k - 1) % 8;
      cyc();
      check("rot_tick", 16'(slot_tick), 16'(c == 0));
      check("rot_idx",  16'(slot_idx),  16'(s));
      if (c >= GD) begin
        check("rot_an",  16'(an),  16'(an_tab[s]));
        check("rot_seg", 16'(seg), 16'(seg_tab[s]));
      end
    end

    // blanking
    blank = 4'b0101;
    digit0 = 4'h8; digit1 = 4'h8; digit2 = 4'h8; digit3 = 4'h8;
    run_until(3, DIV-1);
    for (int k = 0; k < 32; k++) begin
      cyc();
      if (m_idx % 2 == 0) begin
        check("blk_an",  16'(an),  16'(4'b1111));
        check("blk_seg", 16'(seg), 16'(7'b1111111));
      end else if (m_cnt >= GD) begin
        check("vis_an",  16'(an),  16'(m_idx == 1 ? 4'b1101 : 4'b0111));
        check("vis_seg", 16'(seg), 16'(7'b0000000));
      end
    end

    // mid-slot change
    blank = 4'b0000;
    digit1 = 4'hA;
    run_until(1, 4);
    digit1 = 4'hF;
    for (int k = 5; k < DIV; k++) begin
      cyc();
      check("mid_hold_seg", 16'(seg), 16'(7'b0001000));
    end
    run_until(1, GD);
    check("mid_new_seg", 16'(seg), 16'(7'b0001110));

    // enable freeze
    run_until(2, 5);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("frz_an",   16'(an),        16'(4'b1111));
      check("frz_tick", 16'(slot_tick), 16'(0));
      check("frz_idx",  16'(slot_idx),  16'(2));
    end
    enable = 1'b1;
    cyc();
    check("res6_an", 16'(an), 16'(4'b1011));
    cyc();
    check("res7_idx", 16'(slot_idx), 16'(2));
    cyc();
    check("res_tick", 16'(slot_tick), 16'(1));
    check("res_idx",  16'(slot_idx),  16'(3));

    // reset mid-operation
    run_until(3, 4);
    reset = 1'b1;
    cyc();
    check("mrst_an",  16'(an),       16'(4'b1111));
    check("mrst_seg", 16'(seg),      16'(7'b1111111));
    check("mrst_idx", 16'(slot_idx), 16'(0));
    reset = 1'b0;
    cyc();
    check("mrst_tick", 16'(slot_tick), 16'(1));
    for (int k = 0; k < 10; k++) cyc();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
